// File: rtl/add128_operand_sequencer.sv
// add128_operand_sequencer: registers operands onto an external W-bit adder, waits SETTLE cycles, hands the result downstream (define ADDSEQ_CHECK_EN for the sticky reference check)
module add128_operand_sequencer #(
  parameter int W = 128,
  parameter int SETTLE = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_a_i,
  input  logic [W-1:0]     in_b_i,
  input  logic             in_cin_i,
  output logic [W-1:0]     add_a_o,
  output logic [W-1:0]     add_b_o,
  output logic             add_cin_o,
  input  logic [W-1:0]     add_s_i,
  input  logic             add_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_sum_o,
  output logic             out_cout_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic             chk_err_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;
  localparam logic [3:0] LOAD = 4'((SETTLE < 1 ? 1 : SETTLE) - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [W-1:0] add_a_q, add_b_q, sum_q;
  logic add_cin_q, cout_q;
  logic [CNT_W-1:0] op_count_q;
  logic accept, capture, handshake;
  assign accept = in_ready_o && in_valid_i;
  assign capture = state_q == ST_SETTLE && cnt_q == 4'd0;
  assign handshake = out_valid_o && out_ready_i;
  assign in_ready_o = rst_n && state_q == ST_IDLE;
  assign out_valid_o = state_q == ST_DONE;
  assign busy_o = state_q != ST_IDLE;
  assign add_a_o = add_a_q;
  assign add_b_o = add_b_q;
  assign add_cin_o = add_cin_q;
  assign out_sum_o = sum_q;
  assign out_cout_o = cout_q;
  assign op_count_o = op_count_q;
  // next state: accept in IDLE, count down the settle window, release on downstream handshake
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (in_valid_i) begin
        state_d = ST_SETTLE;
        cnt_d = LOAD;
      end
      ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_DONE; else cnt_d = cnt_q - 4'd1;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and settle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // adder operands change only on accept, giving the adder a stable multicycle path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_a_q <= '0;
      add_b_q <= '0;
      add_cin_q <= 1'b0;
    end else if (accept) begin
      add_a_q <= in_a_i;
      add_b_q <= in_b_i;
      add_cin_q <= in_cin_i;
    end
  end
  // result capture at the end of the settle window; held until the next capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      cout_q <= 1'b0;
    end else if (capture) begin
      sum_q <= add_s_i;
      cout_q <= add_cout_i;
    end
  end
  // completed output handshakes, wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= '0;
    else if (handshake) op_count_q <= op_count_q + CNT_W'(1);
  end
`ifdef ADDSEQ_CHECK_EN
  logic [W:0] ref_sum;
  logic chk_err_q;
  assign ref_sum = {1'b0, add_a_q} + {1'b0, add_b_q} + {{W{1'b0}}, add_cin_q};
  assign chk_err_o = chk_err_q;
  // sticky flag when the external adder disagrees with the reference at capture
  always_ff @(posedge clk) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else if (capture && ref_sum != {add_cout_i, add_s_i}) chk_err_q <= 1'b1;
  end
`else
  assign chk_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_add128_operand_sequencer.sv
// tb_add128_operand_sequencer: table, directed and random checks against a timeline model of the sequencer
module tb_add128_operand_sequencer;
  localparam int W = 128, S = 2, CW = 16;
`ifdef ADDSEQ_CHECK_EN
  localparam bit CHK_EN = 1;
`else
  localparam bit CHK_EN = 0;
`endif
  logic clk = 0, rst_n = 0, in_valid_i = 0, in_cin_i = 0, out_ready_i = 0, fault = 0;
  logic [W-1:0] in_a_i = '0, in_b_i = '0, add_a_o, add_b_o, add_s_i, out_sum_o;
  logic add_cin_o, add_cout_i, in_ready_o, out_valid_o, out_cout_o, busy_o, chk_err_o;
  logic [CW-1:0] op_count_o;
  logic [W:0] fmask;
  int vectors = 0, miscompares = 0;
  bit pend = 0, mchk = 0;
  int k = 0, cyc = 0;
  logic [W:0] res = '0;
  logic [W-1:0] ma = '0, mb = '0;
  logic mc = 0;
  logic [CW-1:0] cnt = '0;
  int acc[$];
  typedef struct { logic [W-1:0] a, b; logic c; logic [W:0] e; } vec_t;
  vec_t tbl[6];

  add128_operand_sequencer #(.W(W), .SETTLE(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_cin_i(in_cin_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
    .add_s_i(add_s_i), .add_cout_i(add_cout_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_sum_o(out_sum_o), .out_cout_o(out_cout_o),
    .busy_o(busy_o), .op_count_o(op_count_o), .chk_err_o(chk_err_o));

  always #5 clk = ~clk;

  always_comb begin
    fmask = '0;
    fmask[64] = fault;
  end
  assign {add_cout_i, add_s_i} = ({1'b0, add_a_o} + {1'b0, add_b_o} + {{W{1'b0}}, add_cin_o}) ^ fmask;

  task automatic chk(input string n, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic ordy, input logic rn);
    logic ov;
    logic [W:0] fm;
    @(negedge clk);
    rst_n = rn; in_valid_i = iv; in_a_i = a; in_b_i = b; in_cin_i = c; out_ready_i = ordy;
    #1;
    ov = pend && cyc > k + S;
    chk("in_ready", in_ready_o, rn && !pend);
    chk("out_valid", out_valid_o, ov);
    chk("busy", busy_o, pend);
    chk("op_count", op_count_o, cnt);
    chk("result", {out_cout_o, out_sum_o}, res);
    chk("add_a", add_a_o, ma);
    chk("add_b", add_b_o, mb);
    chk("add_cin", add_cin_o, mc);
    chk("chk_err", chk_err_o, mchk);
    if (!rn) begin
      pend = 0; res = '0; cnt = '0; ma = '0; mb = '0; mc = 0; mchk = 0;
    end else if (!pend) begin
      if (iv) begin
        pend = 1; k = cyc; ma = a; mb = b; mc = c; acc.push_back(cyc);
      end
    end else if (cyc == k + S) begin
      fm = '0;
      fm[64] = fault;
      res = ({1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc}) ^ fm;
      if (fault && CHK_EN) mchk = 1;
    end else if (ov && ordy) begin
      pend = 0; cnt++;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    cycle(1, a, b, c, 1, 1);
    for (int i = 0; i < S + 1; i++) cycle(0, '0, '0, 0, 1, 1);
  endtask

  initial begin
    tbl[0] = '{{W{1'b1}}, W'(1), 1'b0, {1'b1, {W{1'b0}}}};
    tbl[1] = '{W'(5), W'(7), 1'b1, (W+1)'(13)};
    tbl[2] = '{W'(0), W'(0), 1'b0, (W+1)'(0)};
    tbl[3] = '{{W{1'b1}}, {W{1'b1}}, 1'b1, {1'b1, {W{1'b1}}}};
    tbl[4] = '{W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, {64'd0, 1'b1, 64'd0}};
    tbl[5] = '{{1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b1, {1'b1, W'(1)}};
    @(posedge clk);
    cyc = 1;
    for (int i = 0; i < 3; i++) cycle(1, {W{1'b1}}, W'(3), 1, 1, 0);
    cycle(0, W'(9), W'(9), 0, 1, 1);
    cycle(0, W'(9), W'(9), 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c);
      #1 chk($sformatf("tbl%0d", i), {out_cout_o, out_sum_o}, tbl[i].e);
    end
    chk("count_after_tbl", op_count_o, CW'(6));
    cycle(1, W'(5), W'(7), 1, 0, 1);
    for (int i = 0; i < 2 + 5; i++) cycle(1, W'(100), W'(200), 0, 0, 1);
    chk("bp_sum", {out_cout_o, out_sum_o}, (W+1)'(13));
    chk("bp_hold_a", add_a_o, W'(5));
    cycle(0, '0, '0, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 1);
    acc.delete();
    for (int i = 0; i < 17; i++) cycle(1, {$urandom, $urandom, $urandom, $urandom}, W'($urandom), 1'($urandom), 1, 1);
    chk("b2b_accepts", acc.size() >= 4, 1);
    for (int i = 1; i < acc.size(); i++) chk("b2b_space", acc[i] - acc[i-1], S + 2);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 1, 1);
    cycle(1, W'(77), W'(1), 0, 1, 1);
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 1, 1);
    chk("midrst_count", op_count_o, CW'(0));
    chk("midrst_add_a", add_a_o, W'(0));
    fault = 1;
    run_op(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 0);
    fault = 0;
    run_op(W'(3), W'(4), 0);
    run_op(W'(8), W'(8), 1);
    chk("chk_sticky", chk_err_o, CHK_EN);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'($urandom), 1'($urandom), $urandom_range(0, 49) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add128_operand_sequencer.md
Name: add128_operand_sequencer

Overview:
- Wraps the 128-bit combinational adder (carry-skip or ripple) as a multicycle stage.
- Accepts an operand pair over a valid/ready handshake and registers it onto the adder inputs, holding them stable.
- Waits a programmable number of settle cycles, then captures sum and carry-out and presents them downstream over a second valid/ready handshake.
- The adder instance sits outside this block, between the add_* output and input ports.

Parameters:
- W, 128, operand/sum width; must match adder width.
- SETTLE, 2, cycles allowed for adder propagation; legal 1..15; 0 is treated as 1.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in.
- add_a  out  W  registered A to adder.
- add_b  out  W  registered B to adder.
- add_cin  out  1  registered carry-in to adder.
- add_s  in  W  adder sum.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  W  captured sum.
- out_cout  out  1  captured carry-out.
- busy  out  1  high in SETTLE or DONE.
- op_count  out  CNT_W  completed output handshakes, wraps.
- chk_err  out  1  sticky adder-mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clock edge):
  - state forced to IDLE.
  - add_a, add_b, add_cin, out_sum, out_cout, op_count, chk_err, settle counter all 0.
  - out_valid 0; busy 0.
  - in_ready forced 0 while rst_n is low.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: register in_a/in_b/in_cin onto add_a/add_b/add_cin, load counter = SETTLE-1, go to SETTLE.
- SETTLE:
  - in_ready = 0.
  - At each edge: if counter == 0, capture add_s→out_sum and add_cout→out_cout, set out_valid, go to DONE; otherwise decrement the counter.
- DONE:
  - out_valid = 1; out_sum/out_cout held stable.
  - On an edge with out_valid & out_ready: clear out_valid, op_count += 1 (wraps 2^CNT_W-1 → 0), go to IDLE.
- Latency:
  - Accept at edge k; capture at edge k+SETTLE; out_valid high in the cycle after edge k+SETTLE.
  - With out_ready held high, minimum accept-to-accept spacing is SETTLE+2 cycles.
- add_a/add_b/add_cin change only on an accept edge or on reset; stable through SETTLE and DONE (multicycle-path guarantee).
- in_valid while not IDLE is ignored; operands are not sampled, and the upstream holds them.
- out_ready while not DONE has no effect.
- Reset mid-SETTLE or mid-DONE: the operation is discarded, no out_valid pulse, op_count is not incremented.
- out_sum/out_cout are unchanged by an accept and hold the previous result until the next capture.

Optional Feature:
- Macro: ADDSEQ_CHECK_EN.
- Defined:
  - At the capture edge, compute the behavioural reference {cout,sum} = add_a + add_b + add_cin at width W+1.
  - If it differs from {add_cout, add_s}, set chk_err.
  - chk_err is sticky and cleared only by reset.
- Undefined: chk_err tied to 0; no reference adder synthesised.

Test Plan:
- Reset hold: rst_n low 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all outputs 0; no accept after release until in_valid is sampled in IDLE.
- Carry ripple, SETTLE=2, behavioural adder: A=all-ones, B=1, cin=0 → out_sum=0, out_cout=1; out_valid first high in the cycle after accept edge+2; op_count=1 after handshake.
- Backpressure: A=5, B=7, cin=1, out_ready low 5 cycles → out_sum=13 stable, in_ready=0, a second in_valid is not accepted; releasing out_ready → IDLE next cycle.
- Back-to-back: 4 ops with in_valid/out_ready held high → accepts spaced exactly 4 cycles (SETTLE+2); op_count=4; add_a constant during each SETTLE window.
- Reset mid-SETTLE: rst_n low for one edge at counter=1 → state IDLE, out_valid never asserted, op_count=0, add_a=0.
- Checker: adder model with bit 64 forced inverted, ADDSEQ_CHECK_EN defined → chk_err=1 after first capture and still 1 after later correct ops; macro undefined → chk_err=0 throughout.
